// File: rtl/bpu_update_sched.sv
// rtl/bpu_update_sched.sv - in-order BHT/BTB update scheduler with starvation guard
module bpu_update_sched #(
   parameter int BHTBTB_INDEX_WIDTH = 9,
   parameter int DEPTH              = 4,
   parameter int STALL_LIMIT        = 8
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            req0_valid,
   output logic                            req0_ready,
   input  logic [31:0]                     req0_pc,
   input  logic                            req0_inc,
   input  logic                            req0_dec,
   input  logic                            req0_btb_we,
   input  logic [31:0]                     req0_target,
   input  logic                            req1_valid,
   output logic                            req1_ready,
   input  logic [31:0]                     req1_pc,
   input  logic                            req1_inc,
   input  logic                            req1_dec,
   input  logic                            req1_btb_we,
   input  logic [31:0]                     req1_target,
   input  logic                            btb_rd_busy,
   output logic                            fetch_hold,
   output logic                            bht_write_enable,
   output logic                            bht_valid_in,
   output logic                            bht_write_inc,
   output logic                            bht_write_dec,
   output logic [BHTBTB_INDEX_WIDTH-1:0]   bht_write_index,
   output logic [1:0]                      bht_write_counter_select,
   output logic                            btb_ce,
   output logic                            btb_we,
   output logic [BHTBTB_INDEX_WIDTH-1:0]   btb_write_index,
   output logic [128:0]                    btb_wmask,
   output logic [128:0]                    btb_din,
   output logic [$clog2(DEPTH):0]          occupancy,
   output logic [31:0]                     stall_cnt_total
);

   localparam int PW  = $clog2(DEPTH);
   localparam int OW  = PW + 1;
   localparam int CW  = $clog2(STALL_LIMIT) + 1;
   localparam int PCW = BHTBTB_INDEX_WIDTH + 2;
   localparam logic [OW-1:0] DEPTH_V  = OW'(DEPTH);
   localparam logic [CW-1:0] LIMIT_M1 = CW'(STALL_LIMIT - 1);

   typedef struct packed {
      logic [PCW-1:0] pc;
      logic           inc;
      logic           dec;
      logic           btb_we;
      logic [31:0]    target;
   } entry_t;

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_STALL, S_FORCE} state_t;

   entry_t         mem_q [DEPTH];
   entry_t         mem_d [DEPTH];
   logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
   logic [OW-1:0]  occ_q, occ_d;
   state_t         state_q, state_d;
   logic [CW-1:0]  stall_q, stall_d;
   logic [31:0]    total_q, total_d;
   logic           fetch_hold_q, fetch_hold_d;

   entry_t head_e, entry0, entry1;
   logic   nonempty, issue, blocked, acc0, acc1;

   logic unused_pc_bits;
   assign unused_pc_bits = ^{req0_pc[31:BHTBTB_INDEX_WIDTH+4], req0_pc[1:0],
                             req1_pc[31:BHTBTB_INDEX_WIDTH+4], req1_pc[1:0]};

   assign head_e   = mem_q[head_q];
   assign nonempty = (occ_q != '0);
   assign issue    = nonempty && (!head_e.btb_we || !btb_rd_busy);
   assign blocked  = nonempty && !issue;

   // Ready looks only at registered occupancy, so a full FIFO stays closed on a pop cycle.
   assign req0_ready = (occ_q < DEPTH_V);
   assign req1_ready = ((occ_q + OW'(req0_valid)) < DEPTH_V);
   assign acc0       = req0_valid && req0_ready;
   assign acc1       = req1_valid && req1_ready;

   assign entry0 = '{pc: req0_pc[BHTBTB_INDEX_WIDTH+3:2], inc: req0_inc, dec: req0_dec,
                     btb_we: req0_btb_we, target: req0_target};
   assign entry1 = '{pc: req1_pc[BHTBTB_INDEX_WIDTH+3:2], inc: req1_inc, dec: req1_dec,
                     btb_we: req1_btb_we, target: req1_target};

   always_comb begin
      mem_d  = mem_q;
      tail_d = tail_q;
      if (acc0) begin
         mem_d[tail_d] = entry0;
         tail_d        = tail_d + PW'(1);
      end
      if (acc1) begin
         mem_d[tail_d] = entry1;
         tail_d        = tail_d + PW'(1);
      end
      head_d = head_q + PW'(issue);
      occ_d  = occ_q + OW'(acc0) + OW'(acc1) - OW'(issue);
   end

   always_comb begin
      state_d = state_q;
      stall_d = stall_q;
      total_d = total_q;
      if ((state_q == S_STALL || state_q == S_FORCE) && total_q != '1)
         total_d = total_q + 32'd1;
      case (state_q)
         S_IDLE: begin
            if (acc0 || acc1) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (blocked)             state_d = S_STALL;
            else if (occ_d == '0)    state_d = S_IDLE;
         end
         S_STALL: begin
            if (issue) begin
               stall_d = '0;
               state_d = (occ_d == '0) ? S_IDLE : S_DRAIN;
            end else if (stall_q == LIMIT_M1) begin
               state_d = S_FORCE;
            end else begin
               stall_d = stall_q + CW'(1);
            end
         end
         S_FORCE: begin
            // A busy fetch while held simply keeps us here; the head cannot issue anyway.
            if (issue) begin
               stall_d = '0;
               state_d = (occ_d == '0) ? S_IDLE : S_DRAIN;
            end
         end
         default: state_d = S_IDLE;
      endcase
      fetch_hold_d = (state_d == S_FORCE);
   end

   always_comb begin
      bht_write_enable         = 1'b0;
      bht_valid_in             = 1'b0;
      bht_write_inc            = 1'b0;
      bht_write_dec            = 1'b0;
      bht_write_index          = '0;
      bht_write_counter_select = 2'b00;
      btb_ce                   = 1'b0;
      btb_we                   = 1'b0;
      btb_write_index          = '0;
      btb_wmask                = '0;
      btb_din                  = '0;
      if (issue) begin
         bht_write_enable         = 1'b1;
         bht_valid_in             = 1'b1;
         bht_write_inc            = head_e.inc;
         bht_write_dec            = head_e.dec;
         bht_write_index          = head_e.pc[PCW-1:2];
         bht_write_counter_select = head_e.pc[1:0];
         if (head_e.btb_we) begin
            btb_ce          = 1'b1;
            btb_we          = 1'b1;
            btb_write_index = head_e.pc[PCW-1:2];
            btb_wmask[128]  = 1'b1;
            btb_din[128]    = 1'b1;
            for (int k = 0; k < 4; k++) begin
               if (head_e.pc[1:0] == 2'(k)) begin
                  btb_wmask[32*k +: 32] = '1;
                  btb_din[32*k +: 32]   = head_e.target;
               end
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q       <= '0;
         tail_q       <= '0;
         occ_q        <= '0;
         state_q      <= S_IDLE;
         stall_q      <= '0;
         total_q      <= '0;
         fetch_hold_q <= 1'b0;
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         occ_q        <= occ_d;
         state_q      <= state_d;
         stall_q      <= stall_d;
         total_q      <= total_d;
         fetch_hold_q <= fetch_hold_d;
      end
   end

   // Storage needs no reset: occupancy gates every read.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   assign occupancy       = occ_q;
   assign fetch_hold      = fetch_hold_q;
   assign stall_cnt_total = total_q;

endmodule

// File: tb/tb_bpu_update_sched.sv
// tb/tb_bpu_update_sched.sv - directed self-checking bench for bpu_update_sched
module tb_bpu_update_sched;

   logic         clock, reset;
   logic         req0_valid, req0_ready, req0_inc, req0_dec, req0_btb_we;
   logic [31:0]  req0_pc, req0_target;
   logic         req1_valid, req1_ready, req1_inc, req1_dec, req1_btb_we;
   logic [31:0]  req1_pc, req1_target;
   logic         btb_rd_busy, fetch_hold;
   logic         bht_write_enable, bht_valid_in, bht_write_inc, bht_write_dec;
   logic [8:0]   bht_write_index, btb_write_index;
   logic [1:0]   bht_write_counter_select;
   logic         btb_ce, btb_we;
   logic [128:0] btb_wmask, btb_din;
   logic [2:0]   occupancy;
   logic [31:0]  stall_cnt_total;

   int vec_cnt = 0;
   int err_cnt = 0;

   bpu_update_sched dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_pc(req0_pc),
      .req0_inc(req0_inc), .req0_dec(req0_dec), .req0_btb_we(req0_btb_we),
      .req0_target(req0_target),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_pc(req1_pc),
      .req1_inc(req1_inc), .req1_dec(req1_dec), .req1_btb_we(req1_btb_we),
      .req1_target(req1_target),
      .btb_rd_busy(btb_rd_busy), .fetch_hold(fetch_hold),
      .bht_write_enable(bht_write_enable), .bht_valid_in(bht_valid_in),
      .bht_write_inc(bht_write_inc), .bht_write_dec(bht_write_dec),
      .bht_write_index(bht_write_index),
      .bht_write_counter_select(bht_write_counter_select),
      .btb_ce(btb_ce), .btb_we(btb_we), .btb_write_index(btb_write_index),
      .btb_wmask(btb_wmask), .btb_din(btb_din),
      .occupancy(occupancy), .stall_cnt_total(stall_cnt_total)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs;
      req0_valid = 0; req0_pc = 0; req0_inc = 0; req0_dec = 0; req0_btb_we = 0; req0_target = 0;
      req1_valid = 0; req1_pc = 0; req1_inc = 0; req1_dec = 0; req1_btb_we = 0; req1_target = 0;
      btb_rd_busy = 0;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   task automatic set_req0(input logic v, input logic [31:0] pc, input logic inc,
                           input logic we, input logic [31:0] tgt);
      req0_valid = v; req0_pc = pc; req0_inc = inc; req0_dec = ~inc;
      req0_btb_we = we; req0_target = tgt;
   endtask

   task automatic set_req1(input logic v, input logic [31:0] pc, input logic inc,
                           input logic we, input logic [31:0] tgt);
      req1_valid = v; req1_pc = pc; req1_inc = inc; req1_dec = ~inc;
      req1_btb_we = we; req1_target = tgt;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      idle_inputs();
      #12;
      vec_cnt++; if (bht_write_enable !== 1'b0) begin err_cnt++; $display("FAIL rst_bht_en got %b want 0", bht_write_enable); end
      vec_cnt++; if (btb_ce !== 1'b0 || btb_wmask !== 129'd0) begin err_cnt++; $display("FAIL rst_btb got ce=%b mask=%h want 0", btb_ce, btb_wmask); end
      vec_cnt++; if (fetch_hold !== 1'b0) begin err_cnt++; $display("FAIL rst_hold got %b want 0", fetch_hold); end
      vec_cnt++; if (occupancy !== 3'd0) begin err_cnt++; $display("FAIL rst_occ got %0d want 0", occupancy); end
      vec_cnt++; if (stall_cnt_total !== 32'd0) begin err_cnt++; $display("FAIL rst_total got %0d want 0", stall_cnt_total); end
      vec_cnt++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_ready got %b%b want 11", req0_ready, req1_ready); end
      @(posedge clock);
      #1 reset = 1'b0;
   endtask

   task automatic test_single;
      logic [128:0] exp_mask, exp_din;
      exp_mask = {1'b1, 32'h0, 32'hFFFF_FFFF, 64'h0};
      exp_din  = {1'b1, 32'h0, 32'h8000_0100, 64'h0};
      do_reset();
      set_req0(1, 32'h8000_0018, 1, 1, 32'h8000_0100);
      #1;
      vec_cnt++; if (req0_ready !== 1'b1) begin err_cnt++; $display("FAIL single_ready got %b want 1", req0_ready); end
      tick();
      set_req0(0, 0, 0, 0, 0);
      #1;
      vec_cnt++; if (bht_write_enable !== 1'b1 || bht_valid_in !== 1'b1) begin err_cnt++; $display("FAIL single_bht_en got %b%b want 11", bht_write_enable, bht_valid_in); end
      vec_cnt++; if (bht_write_index !== 9'd1 || bht_write_counter_select !== 2'd2) begin err_cnt++; $display("FAIL single_idx got %0d/%0d want 1/2", bht_write_index, bht_write_counter_select); end
      vec_cnt++; if (bht_write_inc !== 1'b1 || bht_write_dec !== 1'b0) begin err_cnt++; $display("FAIL single_dir got %b%b want 10", bht_write_inc, bht_write_dec); end
      vec_cnt++; if (btb_ce !== 1'b1 || btb_we !== 1'b1 || btb_write_index !== 9'd1) begin err_cnt++; $display("FAIL single_btb got ce=%b we=%b idx=%0d want 1 1 1", btb_ce, btb_we, btb_write_index); end
      vec_cnt++; if (btb_wmask !== exp_mask) begin err_cnt++; $display("FAIL single_mask got %h want %h", btb_wmask, exp_mask); end
      vec_cnt++; if (btb_din !== exp_din) begin err_cnt++; $display("FAIL single_din got %h want %h", btb_din, exp_din); end
      vec_cnt++; if (occupancy !== 3'd1) begin err_cnt++; $display("FAIL single_occ1 got %0d want 1", occupancy); end
      tick();
      vec_cnt++; if (occupancy !== 3'd0 || bht_write_enable !== 1'b0) begin err_cnt++; $display("FAIL single_done got occ=%0d en=%b want 0 0", occupancy, bht_write_enable); end
   endtask

   task automatic test_dual;
      do_reset();
      set_req0(1, 32'h0, 1, 0, 0);
      set_req1(1, 32'h4, 0, 0, 0);
      #1;
      vec_cnt++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin err_cnt++; $display("FAIL dual_ready got %b%b want 11", req0_ready, req1_ready); end
      tick();
      idle_inputs();
      #1;
      vec_cnt++; if (bht_write_enable !== 1'b1 || bht_write_counter_select !== 2'd0 || bht_write_inc !== 1'b1) begin err_cnt++; $display("FAIL dual_first got en=%b sel=%0d inc=%b want 1 0 1", bht_write_enable, bht_write_counter_select, bht_write_inc); end
      vec_cnt++; if (btb_ce !== 1'b0 || occupancy !== 3'd2) begin err_cnt++; $display("FAIL dual_occ2 got ce=%b occ=%0d want 0 2", btb_ce, occupancy); end
      tick();
      vec_cnt++; if (bht_write_enable !== 1'b1 || bht_write_counter_select !== 2'd1 || bht_write_dec !== 1'b1) begin err_cnt++; $display("FAIL dual_second got en=%b sel=%0d dec=%b want 1 1 1", bht_write_enable, bht_write_counter_select, bht_write_dec); end
      tick();
      vec_cnt++; if (bht_write_enable !== 1'b0 || occupancy !== 3'd0) begin err_cnt++; $display("FAIL dual_done got en=%b occ=%0d want 0 0", bht_write_enable, occupancy); end
   endtask

   task automatic test_full;
      do_reset();
      btb_rd_busy = 1;
      set_req0(1, 32'h10, 1, 1, 32'hA0);
      set_req1(1, 32'h24, 0, 0, 0);
      tick();
      set_req1(0, 0, 0, 0, 0);
      set_req0(1, 32'h38, 1, 0, 0);
      #1;
      vec_cnt++; if (occupancy !== 3'd2 || bht_write_enable !== 1'b0) begin err_cnt++; $display("FAIL full_blk got occ=%0d en=%b want 2 0", occupancy, bht_write_enable); end
      tick();
      set_req0(1, 32'h4C, 1, 0, 0);
      set_req1(1, 32'h50, 1, 0, 0);
      #1;
      vec_cnt++; if (occupancy !== 3'd3 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin err_cnt++; $display("FAIL full_occ3 got occ=%0d rdy=%b%b want 3 10", occupancy, req0_ready, req1_ready); end
      tick();
      vec_cnt++; if (occupancy !== 3'd4 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin err_cnt++; $display("FAIL full_occ4 got occ=%0d rdy=%b%b want 4 00", occupancy, req0_ready, req1_ready); end
      btb_rd_busy = 0;
      #1;
      vec_cnt++; if (bht_write_enable !== 1'b1 || bht_write_index !== 9'd1 || btb_ce !== 1'b1 || req0_ready !== 1'b0) begin err_cnt++; $display("FAIL full_pop got en=%b idx=%0d ce=%b rdy=%b want 1 1 1 0", bht_write_enable, bht_write_index, btb_ce, req0_ready); end
      tick();
      idle_inputs();
      #1;
      vec_cnt++; if (occupancy !== 3'd3 || bht_write_index !== 9'd2 || bht_write_counter_select !== 2'd1 || bht_write_dec !== 1'b1 || btb_ce !== 1'b0) begin err_cnt++; $display("FAIL full_next got occ=%0d idx=%0d sel=%0d dec=%b ce=%b want 3 2 1 1 0", occupancy, bht_write_index, bht_write_counter_select, bht_write_dec, btb_ce); end
   endtask

   task automatic test_starvation;
      do_reset();
      btb_rd_busy = 1;
      set_req0(1, 32'h8000_0018, 1, 1, 32'h1234_5678);
      tick();
      set_req0(0, 0, 0, 0, 0);
      #1;
      vec_cnt++; if (fetch_hold !== 1'b0 || bht_write_enable !== 1'b0) begin err_cnt++; $display("FAIL starve_c0 got hold=%b en=%b want 0 0", fetch_hold, bht_write_enable); end
      repeat (8) tick();
      vec_cnt++; if (fetch_hold !== 1'b0 || stall_cnt_total !== 32'd7) begin err_cnt++; $display("FAIL starve_c8 got hold=%b total=%0d want 0 7", fetch_hold, stall_cnt_total); end
      tick();
      vec_cnt++; if (fetch_hold !== 1'b1 || stall_cnt_total !== 32'd8 || bht_write_enable !== 1'b0) begin err_cnt++; $display("FAIL starve_force got hold=%b total=%0d en=%b want 1 8 0", fetch_hold, stall_cnt_total, bht_write_enable); end
      repeat (2) tick();
      vec_cnt++; if (fetch_hold !== 1'b1 || bht_write_enable !== 1'b0 || stall_cnt_total !== 32'd10) begin err_cnt++; $display("FAIL starve_violate got hold=%b en=%b total=%0d want 1 0 10", fetch_hold, bht_write_enable, stall_cnt_total); end
      btb_rd_busy = 0;
      #1;
      vec_cnt++; if (btb_we !== 1'b1 || btb_din[95:64] !== 32'h1234_5678 || bht_write_enable !== 1'b1) begin err_cnt++; $display("FAIL starve_issue got we=%b din=%h en=%b want 1 12345678 1", btb_we, btb_din[95:64], bht_write_enable); end
      tick();
      vec_cnt++; if (fetch_hold !== 1'b0 || stall_cnt_total !== 32'd11 || occupancy !== 3'd0) begin err_cnt++; $display("FAIL starve_end got hold=%b total=%0d occ=%0d want 0 11 0", fetch_hold, stall_cnt_total, occupancy); end
   endtask

   task automatic test_bht_behind;
      do_reset();
      btb_rd_busy = 1;
      set_req0(1, 32'h20, 0, 1, 32'h55);
      set_req1(1, 32'h34, 1, 0, 0);
      tick();
      set_req0(0, 0, 0, 0, 0);
      set_req1(0, 0, 0, 0, 0);
      repeat (2) begin
         #1;
         vec_cnt++; if (bht_write_enable !== 1'b0 || occupancy !== 3'd2) begin err_cnt++; $display("FAIL behind_hold got en=%b occ=%0d want 0 2", bht_write_enable, occupancy); end
         tick();
      end
      btb_rd_busy = 0;
      #1;
      vec_cnt++; if (bht_write_enable !== 1'b1 || bht_write_index !== 9'd2 || btb_ce !== 1'b1) begin err_cnt++; $display("FAIL behind_head got en=%b idx=%0d ce=%b want 1 2 1", bht_write_enable, bht_write_index, btb_ce); end
      tick();
      vec_cnt++; if (bht_write_enable !== 1'b1 || bht_write_index !== 9'd3 || bht_write_counter_select !== 2'd1 || btb_ce !== 1'b0) begin err_cnt++; $display("FAIL behind_young got en=%b idx=%0d sel=%0d ce=%b want 1 3 1 0", bht_write_enable, bht_write_index, bht_write_counter_select, btb_ce); end
      tick();
      vec_cnt++; if (bht_write_enable !== 1'b0 || occupancy !== 3'd0) begin err_cnt++; $display("FAIL behind_done got en=%b occ=%0d want 0 0", bht_write_enable, occupancy); end
   endtask

   task automatic test_reset_mid;
      do_reset();
      btb_rd_busy = 1;
      set_req0(1, 32'h10, 1, 1, 32'h77);
      set_req1(1, 32'h14, 1, 0, 0);
      tick();
      set_req1(0, 0, 0, 0, 0);
      set_req0(1, 32'h18, 1, 0, 0);
      tick();
      set_req0(0, 0, 0, 0, 0);
      #1;
      vec_cnt++; if (occupancy !== 3'd3) begin err_cnt++; $display("FAIL mid_occ3 got %0d want 3", occupancy); end
      reset = 1'b1;
      btb_rd_busy = 0;
      #1;
      vec_cnt++; if (occupancy !== 3'd0 || bht_write_enable !== 1'b0 || btb_ce !== 1'b0 || btb_wmask !== 129'd0) begin err_cnt++; $display("FAIL mid_async got occ=%0d en=%b ce=%b want 0 0 0", occupancy, bht_write_enable, btb_ce); end
      @(posedge clock);
      #1 reset = 1'b0;
      repeat (2) begin
         tick();
         vec_cnt++; if (bht_write_enable !== 1'b0 || btb_ce !== 1'b0 || occupancy !== 3'd0 || fetch_hold !== 1'b0) begin err_cnt++; $display("FAIL mid_after got en=%b ce=%b occ=%0d hold=%b want 0 0 0 0", bht_write_enable, btb_ce, occupancy, fetch_hold); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_dual();
      test_full();
      test_starvation();
      test_bht_behind();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/bpu_update_sched.md
# bpu_update_sched

Branch-predictor update scheduler between the two branch-resolution lanes and the shared BHT/BTB write ports. Each lane presents at most one resolved-branch update per cycle; the block queues updates in order in a DEPTH-entry FIFO and issues one BHT counter update, plus an optional BTB target write, per cycle. A BTB write yields to fetch-side BTB reads, and a starvation guard forces fetch to hold so a queued write cannot stall indefinitely.

## Interface
- BHTBTB_INDEX_WIDTH, 9, BHT/BTB set-index width; the index is pc[BHTBTB_INDEX_WIDTH+3:4].
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- STALL_LIMIT, 8, consecutive stalled cycles before fetch_hold is raised.
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- reqN_valid (N=0,1)  in  1  lane N update request.
- reqN_ready  out  1  lane N request accepted this cycle.
- reqN_pc  in  32  branch PC.
- reqN_inc, reqN_dec  in  1  BHT counter direction; exactly one is high when valid.
- reqN_btb_we  in  1  the entry also writes the BTB.
- reqN_target  in  32  BTB target.
- btb_rd_busy  in  1  fetch is reading the BTB this cycle.
- fetch_hold  out  1  asks fetch to leave btb_rd_busy low next cycle.
- bht_write_enable, bht_valid_in, bht_write_inc, bht_write_dec  out  1  BHT write strobes.
- bht_write_index  out  BHTBTB_INDEX_WIDTH  BHT set.
- bht_write_counter_select  out  2  counter slot, pc[3:2].
- btb_ce, btb_we  out  1  BTB write strobes.
- btb_write_index  out  9  BTB set.
- btb_wmask, btb_din  out  129  BTB mask and data; bit 128 is the valid bit, slot k occupies bits [32k+31:32k].
- occupancy  out  $clog2(DEPTH)+1  FIFO entry count.
- stall_cnt_total  out  32  PMU count of cycles a BTB write was blocked; saturates.

## Operation
- **FIFO entry:** {pc[BHTBTB_INDEX_WIDTH+3:2], inc, dec, btb_we, target}. Head and tail pointers wrap modulo DEPTH.
- **Ready rules:** both use registered occupancy only, ignoring any same-cycle pop.
  - req0_ready = occupancy < DEPTH.
  - req1_ready = occupancy + req0_valid < DEPTH.
- **Enqueue order:** when both lanes are accepted in one cycle, lane 0 goes in before lane 1 (lane 0 is older in program order).
- **Issue eligibility:** the head issues when the FIFO is non-empty and either head.btb_we = 0 or btb_rd_busy = 0.
- **Issue outputs:** are combinational from the head, and all are 0 when the head does not issue.
  - BHT: bht_write_enable = bht_valid_in = 1, inc/dec/index/select from the entry.
  - BTB (only if btb_we): btb_ce = btb_we = 1, wmask = bit 128 plus ones in slot pc[3:2], din = bit 128 plus target in slot pc[3:2], zeros elsewhere.
- **Pop:** happens at the edge ending the issue cycle. A stalled head blocks all younger entries, including BHT-only ones, to keep update order.
- **FSM states:**
  - IDLE: FIFO empty.
  - DRAIN: FIFO non-empty, not stalled.
  - STALL: head blocked; stall counter increments each cycle.
  - FORCE: counter has reached STALL_LIMIT; fetch_hold = 1.
- **FSM transitions:**
  - IDLE→DRAIN on enqueue.
  - DRAIN→IDLE when the last entry pops with no enqueue.
  - DRAIN→STALL on a blocked head.
  - STALL→DRAIN on issue; counter clears.
  - STALL→FORCE when the counter equals STALL_LIMIT-1 and the head is still blocked.
  - FORCE→DRAIN or IDLE on issue; counter clears.
  - If btb_rd_busy is high while in FORCE (fetch violating the hold), stay in FORCE and do not issue.
- **stall_cnt_total:** +1 each cycle in STALL or FORCE; saturates at 2^32-1.

## Timing
- **Reset values:** all write outputs 0, fetch_hold 0, occupancy 0, stall_cnt_total 0, pointers 0, FSM IDLE, stall counter 0. reqN_ready = 1.
- **Reset mid-operation:** asserting reset discards all queued entries immediately (asynchronously); no partial write is held.
- **Latency:** a request accepted at edge E appears on the write ports in the cycle after E, i.e. one cycle later if the FIFO was empty and not stalled. Throughput is one entry per cycle.
- **Simultaneous push and pop on a full FIFO:** the pop happens but the ready signals stay low that cycle. This is intended, because ready uses registered occupancy.
- **fetch_hold:** is registered from the FSM, so it is high for every cycle in FORCE.

## Test plan
- **Single update, empty FIFO:** req0 pc=0x80000018, inc=1, btb_we=1, target=0x80000100 → next cycle bht index=1, select=2, inc=1; btb_wmask bit128 and bits[95:64] set; din[95:64]=0x80000100. occupancy returns to 0.
- **Dual enqueue ordering:** req0 and req1 both valid, pc 0x0 and 0x4, BHT-only → both accepted; select 0 issues first, then select 1 on consecutive cycles.
- **Full FIFO:** hold btb_rd_busy=1 with a BTB-write head; keep enqueuing → occupancy reaches 4, both readys go 0, and req1_ready=0 already at occupancy 3 when req0_valid=1.
- **Starvation:** btb_rd_busy held high with a BTB head → fetch_hold rises after 8 stalled cycles; drop busy → write issues, fetch_hold falls, stall_cnt_total = 8 + FORCE cycles.
- **BHT-only behind a blocked head:** a BHT-only entry queued behind the blocked BTB entry does not issue until the head issues.
- **Reset mid-drain:** reset with occupancy=3 → all outputs 0, occupancy 0, no further writes after release.
